register_bank_nab: RTL

Parametrised successor to the single TTM4 A/B storage register. It provides `NREG` registers of `WIDTH` bits behind one write port and one registered read port. Stores and increments use active-low strobes, and a registered output enable drives the read port. It sits between the TTM4 emulator's ALU and data path. It replaces the fixed per-register store/output blocks and adds in-place increment with carry out and an accepted-store counter.

---
 rtl/register_bank_nab.sv | 78 +++++++
 1 files changed

// File: rtl/register_bank_nab.sv
// rtl/register_bank_nab.sv - NREG x WIDTH register bank with store, increment and registered read
// Active-low strobes; store beats increment on the same register, read sees pre-edge contents.
module register_bank_nab #(
  parameter int WIDTH = 4,
  parameter int NREG  = 4,
  parameter int AW    = 2,
  parameter int CW    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             nST,
  input  logic [AW-1:0]    ST_SEL,
  input  logic [WIDTH-1:0] STOREDATA,
  input  logic             nINC,
  input  logic [AW-1:0]    INC_SEL,
  input  logic             nOUT,
  input  logic [AW-1:0]    OUT_SEL,
  output logic [WIDTH-1:0] LOADDATA,
  output logic             CARRY,
  output logic [CW-1:0]    COUNTER
);

  localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] loaddata_q, loaddata_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    counter_q, counter_d;

  logic             st_ok, inc_ok, inc_go, out_ok;
  logic [WIDTH:0]   inc_sum;

  always_comb begin
    st_ok  = !nST  && ({1'b0, ST_SEL}  < NREG_L);
    inc_ok = !nINC && ({1'b0, INC_SEL} < NREG_L);
    out_ok = !nOUT && ({1'b0, OUT_SEL} < NREG_L);
    // A store to the same register swallows the increment, carry included.
    inc_go = inc_ok && !(st_ok && (ST_SEL == INC_SEL));

    inc_sum = '0;
    if (inc_ok) inc_sum = {1'b0, regs_q[INC_SEL]} + (WIDTH+1)'(1);

    regs_d    = regs_q;
    carry_d   = carry_q;
    counter_d = counter_q;
    if (inc_go) begin
      regs_d[INC_SEL] = inc_sum[WIDTH-1:0];
      carry_d         = inc_sum[WIDTH];
    end
    if (st_ok) begin
      regs_d[ST_SEL] = STOREDATA;
      counter_d      = counter_q + CW'(1);
    end

    loaddata_d = '0;
    if (out_ok) loaddata_d = regs_q[OUT_SEL];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      loaddata_q <= '0;
      carry_q    <= 1'b0;
      counter_q  <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      loaddata_q <= loaddata_d;
      carry_q    <= carry_d;
      counter_q  <= counter_d;
    end
  end

  assign LOADDATA = loaddata_q;
  assign CARRY    = carry_q;
  assign COUNTER  = counter_q;

endmodule
